// File: rtl/axil_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// axil_write_arbiter_if
//   Bundles the write-channel signals of the two-requester AXI-lite write
//   arbiter: the two upstream manager ports (S_AXI_*) and the single
//   downstream subordinate port (M_AXI_*).
//
//   Parameters
//     C_AXI_ADDR_WIDTH : address width on both sides
//     C_AXI_DATA_WIDTH : fixed at 32 (localparam); strobe width = data/8
//
//   Modports
//     slave  : arbiter view (S_AXI valids/data in, readies/resp out;
//              M_AXI valids/data out, readies/resp in)
//     master : environment view, exact mirror of slave
//
//   Upstream vectors are packed per requester: requester i owns bit i of
//   each 1-bit-per-requester signal and slice [i*W +: W] of wider fields.
// ---------------------------------------------------------------------------
interface axil_write_arbiter_if #(
    parameter int C_AXI_ADDR_WIDTH = 4
);
    localparam int C_AXI_DATA_WIDTH = 32;
    localparam int C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH / 8;

    // upstream, two requesters
    logic [1:0]                      S_AXI_AWVALID;
    logic [1:0]                      S_AXI_AWREADY;
    logic [2*C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [1:0]                      S_AXI_WVALID;
    logic [1:0]                      S_AXI_WREADY;
    logic [2*C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [2*C_AXI_STRB_WIDTH-1:0]   S_AXI_WSTRB;
    logic [1:0]                      S_AXI_BVALID;
    logic [1:0]                      S_AXI_BREADY;
    logic [3:0]                      S_AXI_BRESP;

    // downstream, single subordinate
    logic                            M_AXI_AWVALID;
    logic                            M_AXI_AWREADY;
    logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR;
    logic [2:0]                      M_AXI_AWPROT;
    logic                            M_AXI_WVALID;
    logic                            M_AXI_WREADY;
    logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA;
    logic [C_AXI_STRB_WIDTH-1:0]     M_AXI_WSTRB;
    logic                            M_AXI_BVALID;
    logic                            M_AXI_BREADY;
    logic [1:0]                      M_AXI_BRESP;

    modport slave (
        input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_WVALID, S_AXI_WDATA,
               S_AXI_WSTRB, S_AXI_BREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
        output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_WVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP
    );

    modport master (
        output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_WVALID, S_AXI_WDATA,
               S_AXI_WSTRB, S_AXI_BREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
        input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_WVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP
    );
endinterface

// File: rtl/axil_write_arbiter.sv
// ---------------------------------------------------------------------------
// axil_write_arbiter
//   Shares one AXI-lite subordinate write channel between two AXI-lite
//   managers. Complete writes (AW + W + B) are serialized: one requester is
//   granted in IDLE, its AW and W are forwarded in XFER (either order or the
//   same cycle), and its B is steered back in RESP. Read channels do not pass
//   through this block.
//
//   Ports
//     S_AXI_ACLK   : clock, rising edge
//     S_AXI_ARESET : asynchronous, active-high reset
//     bus          : axil_write_arbiter_if.slave (S_AXI_* upstream x2,
//                    M_AXI_* downstream x1)
//
//   Build option
//     AXIL_ARB_ROUND_ROBIN_EN : when defined, a tie in IDLE goes to the
//                               requester not served last; otherwise
//                               requester 0 always wins a tie.
// ---------------------------------------------------------------------------
module axil_write_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    axil_write_arbiter_if.slave   bus
);
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    logic   r_grant;
    logic   r_last;
    logic   r_aw_done;
    logic   r_w_done;

    logic   [1:0] w_req;
    logic   w_pick;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_b_hs;

    // Only AWVALID opens a transaction; a lone WVALID waits in IDLE.
    assign w_req = bus.S_AXI_AWVALID;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    // Tie goes to whoever was not served last, so a waiting requester sees
    // at most one foreign write before its own.
    assign w_pick = (&w_req) ? ~r_last : w_req[1];
`else
    // Fixed priority: requester 0 wins any tie.
    assign w_pick = ~w_req[0];
`endif

    assign w_aw_hs = bus.M_AXI_AWVALID & bus.M_AXI_AWREADY;
    assign w_w_hs  = bus.M_AXI_WVALID  & bus.M_AXI_WREADY;
    assign w_b_hs  = bus.M_AXI_BVALID  & bus.M_AXI_BREADY;

    // Payload mux follows grant in every state, so downstream address/data
    // are stable and deterministic even while no valid is presented.
    assign bus.M_AXI_AWADDR = r_grant ? bus.S_AXI_AWADDR[AW +: AW] : bus.S_AXI_AWADDR[0 +: AW];
    assign bus.M_AXI_WDATA  = r_grant ? bus.S_AXI_WDATA[DW +: DW]  : bus.S_AXI_WDATA[0 +: DW];
    assign bus.M_AXI_WSTRB  = r_grant ? bus.S_AXI_WSTRB[SW +: SW]  : bus.S_AXI_WSTRB[0 +: SW];
    assign bus.M_AXI_AWPROT = 3'b000;

    // Handshake forwarding for the granted requester only; everything else
    // (including the non-granted requester's ready/valid/resp) is held at 0.
    always_comb begin
        bus.M_AXI_AWVALID = 1'b0;
        bus.M_AXI_WVALID  = 1'b0;
        bus.M_AXI_BREADY  = 1'b0;
        bus.S_AXI_AWREADY = 2'b00;
        bus.S_AXI_WREADY  = 2'b00;
        bus.S_AXI_BVALID  = 2'b00;
        bus.S_AXI_BRESP   = 4'b0000;
        case (r_state)
            XFER: begin
                // *_done masks each channel after its handshake so AW and W
                // each cross exactly once per transaction.
                bus.M_AXI_AWVALID          = bus.S_AXI_AWVALID[r_grant] & ~r_aw_done;
                bus.S_AXI_AWREADY[r_grant] = bus.M_AXI_AWREADY & ~r_aw_done;
                bus.M_AXI_WVALID           = bus.S_AXI_WVALID[r_grant] & ~r_w_done;
                bus.S_AXI_WREADY[r_grant]  = bus.M_AXI_WREADY & ~r_w_done;
            end
            RESP: begin
                bus.M_AXI_BREADY          = bus.S_AXI_BREADY[r_grant];
                bus.S_AXI_BVALID[r_grant] = bus.M_AXI_BVALID;
                if (r_grant)
                    bus.S_AXI_BRESP[3:2] = bus.M_AXI_BRESP;
                else
                    bus.S_AXI_BRESP[1:0] = bus.M_AXI_BRESP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant   <= w_pick;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= XFER;
                    end
                end
                XFER: begin
                    if (w_aw_hs)
                        r_aw_done <= 1'b1;
                    if (w_w_hs)
                        r_w_done <= 1'b1;
                    // Counts a handshake landing this cycle, so AW+W together
                    // move to RESP in a single XFER cycle.
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs))
                        r_state <= RESP;
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_write_arbiter.sv
module tb_axil_write_arbiter;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_write_arbiter_if #(.C_AXI_ADDR_WIDTH(AW)) bus ();

    axil_write_arbiter #(.C_AXI_ADDR_WIDTH(AW)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus)
    );

    int total = 0;
    int bad   = 0;

    // upstream managers: a channel is valid while issued != accepted
    int aw_iss[2] = '{0, 0};
    int w_iss[2]  = '{0, 0};
    int aw_acc[2] = '{0, 0};
    int w_acc[2]  = '{0, 0};
    int b_cnt[2]  = '{0, 0};
    int ord[64];
    int ord_n = 0;
    logic [1:0]    bready;
    logic [AW-1:0] addr[2];
    logic [31:0]   data[2];
    logic [3:0]    strb[2];

    // subordinate model
    logic       sub_awready, sub_wready;
    logic [1:0] sub_bresp;
    logic       sub_b = 1'b0;
    logic       sub_aw_got = 1'b0;
    logic       sub_w_got = 1'b0;
    int         m_aw_cnt = 0;
    int         m_w_cnt = 0;

    assign bus.S_AXI_AWVALID[0] = (aw_iss[0] != aw_acc[0]);
    assign bus.S_AXI_AWVALID[1] = (aw_iss[1] != aw_acc[1]);
    assign bus.S_AXI_WVALID[0]  = (w_iss[0] != w_acc[0]);
    assign bus.S_AXI_WVALID[1]  = (w_iss[1] != w_acc[1]);
    assign bus.S_AXI_AWADDR     = {addr[1], addr[0]};
    assign bus.S_AXI_WDATA      = {data[1], data[0]};
    assign bus.S_AXI_WSTRB      = {strb[1], strb[0]};
    assign bus.S_AXI_BREADY     = bready;
    assign bus.M_AXI_AWREADY    = sub_awready;
    assign bus.M_AXI_WREADY     = sub_wready;
    assign bus.M_AXI_BVALID     = sub_b;
    assign bus.M_AXI_BRESP      = sub_bresp;

    wire m_aw_hs = bus.M_AXI_AWVALID & bus.M_AXI_AWREADY;
    wire m_w_hs  = bus.M_AXI_WVALID & bus.M_AXI_WREADY;
    wire [12:0] outs = {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                        bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                        bus.S_AXI_BRESP};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                aw_acc[i] <= aw_iss[i];
                w_acc[i]  <= w_iss[i];
                b_cnt[i]  <= aw_iss[i];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.S_AXI_AWVALID[i] & bus.S_AXI_AWREADY[i]) begin
                    aw_acc[i]  <= aw_acc[i] + 1;
                    ord[ord_n] <= i;
                    ord_n      <= ord_n + 1;
                end
                if (bus.S_AXI_WVALID[i] & bus.S_AXI_WREADY[i])
                    w_acc[i] <= w_acc[i] + 1;
                if (bus.S_AXI_BVALID[i] & bus.S_AXI_BREADY[i])
                    b_cnt[i] <= b_cnt[i] + 1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_b      <= 1'b0;
            sub_aw_got <= 1'b0;
            sub_w_got  <= 1'b0;
        end else begin
            if (m_aw_hs) m_aw_cnt <= m_aw_cnt + 1;
            if (m_w_hs)  m_w_cnt  <= m_w_cnt + 1;
            if (sub_b) begin
                if (bus.M_AXI_BREADY) sub_b <= 1'b0;
            end else if ((sub_aw_got | m_aw_hs) & (sub_w_got | m_w_hs)) begin
                sub_b      <= 1'b1;
                sub_aw_got <= 1'b0;
                sub_w_got  <= 1'b0;
            end else begin
                if (m_aw_hs) sub_aw_got <= 1'b1;
                if (m_w_hs)  sub_w_got  <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int r, input bit a, input bit w);
        if (a) aw_iss[r]++;
        if (w) w_iss[r]++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!(aw_acc[0] == aw_iss[0] && aw_acc[1] == aw_iss[1] &&
                 w_acc[0] == w_iss[0] && w_acc[1] == w_iss[1] &&
                 b_cnt[0] == aw_iss[0] && b_cnt[1] == aw_iss[1]) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(k < budget), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int base, aw0, w0;
        logic [3:0] exp_o4;
        logic [2:0] exp_o3;
        bready = 2'b11;
        sub_awready = 1'b1;
        sub_wready = 1'b1;
        sub_bresp = 2'b00;
        addr[0] = 4'hA; data[0] = 32'h1111_1111; strb[0] = 4'h3;
        addr[1] = 4'h4; data[1] = 32'hDEAD_BEEF; strb[1] = 4'hF;
        rst = 1'b1;
        tick(2);
        chk("rst_outs", 64'(outs), 64'(0));
        chk("rst_prot", 64'(bus.M_AXI_AWPROT), 64'(0));
        rst = 1'b0;
        tick(1);
        chk("idle_outs", 64'(outs), 64'(0));

        // single write from requester 1
        issue(1, 1, 1);
        #1 chk("t1_idle_no_rdy", 64'(outs), 64'(0));
        tick(1);
        chk("t1_awvalid", 64'(bus.M_AXI_AWVALID), 64'(1));
        chk("t1_awaddr", 64'(bus.M_AXI_AWADDR), 64'(4'h4));
        chk("t1_wdata", 64'(bus.M_AXI_WDATA), 64'(32'hDEAD_BEEF));
        chk("t1_wstrb", 64'(bus.M_AXI_WSTRB), 64'(4'hF));
        chk("t1_rdy", 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 64'(4'b1010));
        tick(1);
        chk("t1_bvalid", 64'(bus.S_AXI_BVALID), 64'(2'b10));
        chk("t1_bresp", 64'(bus.S_AXI_BRESP), 64'(0));
        tick(1);
        chk("t1_idle", 64'(outs), 64'(0));
        chk("t1_hs", {32'(m_aw_cnt), 32'(m_w_cnt)}, {32'd1, 32'd1});

        // simultaneous request, then requester 0 re-requests at once
        addr[0] = 4'h8; addr[1] = 4'hC;
        base = ord_n;
        issue(0, 1, 1);
        issue(1, 1, 1);
        begin
            int k = 0;
            while (b_cnt[0] != aw_iss[0] && k < 20) begin
                tick(1);
                k++;
            end
            chk("t2_first_b", 64'(k < 20), 64'(1));
        end
        issue(0, 1, 1);
        wait_done("t2_done", 40);
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        exp_o3 = 3'b010;
`else
        exp_o3 = 3'b001;
`endif
        chk("t2_order", 64'({ord[base][0], ord[base+1][0], ord[base+2][0]}), 64'(exp_o3));

        // both requesters continuously busy for 4 writes
        do_reset();
        base = ord_n;
        issue(0, 1, 1); issue(0, 1, 1);
        issue(1, 1, 1); issue(1, 1, 1);
        wait_done("t3_done", 80);
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        exp_o4 = 4'b0101;
`else
        exp_o4 = 4'b0011;
`endif
        chk("t3_order", 64'({ord[base][0], ord[base+1][0], ord[base+2][0], ord[base+3][0]}), 64'(exp_o4));

        // W 3 cycles ahead of AW on requester 0
        aw0 = m_aw_cnt; w0 = m_w_cnt;
        issue(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t4_w_only_idle", 64'(outs), 64'(0));
        end
        issue(0, 1, 0);
        tick(1);
        chk("t4_xfer", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID}), 64'(2'b11));
        tick(1);
        chk("t4_resp", 64'(bus.S_AXI_BVALID), 64'(2'b01));
        tick(1);
        chk("t4_hs", {32'(m_aw_cnt - aw0), 32'(m_w_cnt - w0)}, {32'd1, 32'd1});

        // AW 2 cycles ahead of W on requester 1
        aw0 = m_aw_cnt; w0 = m_w_cnt;
        sub_bresp = 2'b11;
        issue(1, 1, 0);
        tick(1);
        chk("t4b_aw_only", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID}), 64'(2'b10));
        tick(1);
        chk("t4b_aw_done", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.S_AXI_AWREADY}), 64'(0));
        issue(1, 0, 1);
        #1 chk("t4b_w", 64'({bus.M_AXI_WVALID, bus.S_AXI_WREADY}), 64'(3'b110));
        tick(1);
        chk("t4b_resp", 64'({bus.S_AXI_BVALID, bus.S_AXI_BRESP}), 64'(6'b10_1100));
        tick(1);
        chk("t4b_hs", {32'(m_aw_cnt - aw0), 32'(m_w_cnt - w0)}, {32'd1, 32'd1});
        sub_bresp = 2'b00;

        // requester 0 holds BREADY low while requester 1 waits
        bready[0] = 1'b0;
        sub_bresp = 2'b10;
        base = ord_n;
        issue(0, 1, 1);
        tick(2);
        issue(1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_bready", 64'(bus.M_AXI_BREADY), 64'(0));
            chk("t5_hold", 64'({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.M_AXI_AWVALID}), 64'(7'b01_0010_0));
            tick(1);
        end
        bready[0] = 1'b1;
        sub_bresp = 2'b00;
        wait_done("t5_done", 30);
        chk("t5_order", 64'({ord[base][0], ord[base+1][0]}), 64'(2'b01));

        // reset after AW handshake, before W
        issue(0, 1, 0);
        tick(2);
        chk("t6_aw_done", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID}), 64'(0));
        rst = 1'b1;
        #1 chk("t6_rst_outs", 64'(outs), 64'(0));
        tick(1);
        rst = 1'b0;
        tick(1);
        base = ord_n;
        issue(0, 1, 1);
        issue(1, 1, 1);
        wait_done("t6_done", 40);
        chk("t6_order", 64'({ord[base][0], ord[base+1][0]}), 64'(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
